// File: rtl/slice_rr_pkg.sv
// -----------------------------------------------------------------------------
// slice_rr_pkg
// Shared definitions for the time-sliced round-robin scheduler:
//   NREQ      - default number of requesters
//   SLICE_W   - default width of each slice-length register (and of the
//               slice down-counter)
//   SLICE_RST - default slice length loaded into every register at reset
//   state_t   - scheduler FSM state encoding
// -----------------------------------------------------------------------------
package slice_rr_pkg;

    localparam int NREQ = 4;
    localparam int SLICE_W = 4;
    localparam logic [SLICE_W-1:0] SLICE_RST = 4'd3;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

endpackage

// File: rtl/slice_rr_scheduler_if.sv
// -----------------------------------------------------------------------------
// slice_rr_scheduler_if
// Bundles the requester side and the slice configuration port of the
// scheduler.
//   req        - per-requester request level (held while access is wanted)
//   cfg_we     - slice-register write strobe
//   cfg_idx    - index of the slice register to write
//   cfg_slice  - slice length in cycles to write
//   gnt        - one-hot grant, or all-zero when nobody owns the resource
//   gnt_id     - encoded index of the current owner (0 when idle)
//   gnt_vld    - high exactly when gnt is non-zero
//   slice_last - high in the final cycle of the current owner's slice
// Modports:
//   master - the requesters / configuration agent
//   slave  - the scheduler
// -----------------------------------------------------------------------------
interface slice_rr_scheduler_if #(
    parameter int NREQ    = slice_rr_pkg::NREQ,
    parameter int SLICE_W = slice_rr_pkg::SLICE_W
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req;
    logic               cfg_we;
    logic [IDX_W-1:0]   cfg_idx;
    logic [SLICE_W-1:0] cfg_slice;

    logic [NREQ-1:0]    gnt;
    logic [IDX_W-1:0]   gnt_id;
    logic               gnt_vld;
    logic               slice_last;

    modport master (
        output req, cfg_we, cfg_idx, cfg_slice,
        input  gnt, gnt_id, gnt_vld, slice_last
    );

    modport slave (
        input  req, cfg_we, cfg_idx, cfg_slice,
        output gnt, gnt_id, gnt_vld, slice_last
    );

endinterface

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority encoder. Scans req starting at index
// 'start' and wrapping modulo NREQ; the first set bit found wins.
//   req    - request vector
//   start  - index with highest priority for this search
//   winner - index of the first set request at or after start (0 if none)
//   found  - high when any request bit is set
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] winner,
    output logic             found
);

    int               pos;
    logic [IDX_W-1:0] pos_idx;

    always_comb begin
        winner  = '0;
        found   = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            // Modulo by subtraction: start < NREQ, so one wrap at most.
            pos = int'(start) + i;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            pos_idx = IDX_W'(pos);
            if (!found && req[pos_idx]) begin
                found  = 1'b1;
                winner = pos_idx;
            end
        end
    end

endmodule

// File: rtl/slice_rr_scheduler.sv
// -----------------------------------------------------------------------------
// slice_rr_scheduler
// Time-sliced round-robin arbiter. Each requester owns the resource for up to
// slice[k] cycles (a programmed 0 counts as 1); on expiry or early release the
// grant rotates to the next pending requester with no idle gap. A lone
// requester whose slice expires is simply re-granted a fresh slice.
//
// Ports:
//   clk - clock, all state updates on the rising edge
//   rst - asynchronous active-high reset
//   bus - slice_rr_scheduler_if.slave (requests, slice config, grant outputs)
//
// State table:
//   state | meaning
//   IDLE  | no owner, gnt=0, next search starts at ptr
//   OWN   | owner_q holds the grant, cnt_q = cycles left after this one
// -----------------------------------------------------------------------------
module slice_rr_scheduler
    import slice_rr_pkg::*;
#(
    parameter int                          NREQ      = slice_rr_pkg::NREQ,
    parameter int                          SLICE_W   = slice_rr_pkg::SLICE_W,
    parameter logic [slice_rr_pkg::SLICE_W-1:0] SLICE_RST = slice_rr_pkg::SLICE_RST
) (
    input  logic                 clk,
    input  logic                 rst,
    slice_rr_scheduler_if.slave  bus
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [SLICE_W-1:0] cnt_q, cnt_d;
    logic [SLICE_W-1:0] slice_q [NREQ];

    logic [IDX_W-1:0]   search_start;
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        if (i == IDX_W'(NREQ - 1)) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    // Counter load value: slice length minus the cycle being granted now.
    // A programmed 0 behaves like 1, so it also loads 0.
    function automatic logic [SLICE_W-1:0] load_val(input logic [SLICE_W-1:0] s);
        return (s == '0) ? '0 : s - 1'b1;
    endfunction

    // While owning, the current owner is checked last; while idle the
    // search resumes just past the previous owner.
    assign search_start = (state_q == OWN) ? next_idx(owner_q) : ptr_q;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (bus.req),
        .start  (search_start),
        .winner (win_idx),
        .found  (win_found)
    );

    // Slice length registers. A load in the same cycle as a write reads the
    // old value, since the FSM samples slice_q before this edge commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                slice_q[i] <= SLICE_RST;
            end
        end else if (bus.cfg_we) begin
            slice_q[bus.cfg_idx] <= bus.cfg_slice;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = OWN;
                    owner_d = win_idx;
                    ptr_d   = next_idx(win_idx);
                    cnt_d   = load_val(slice_q[win_idx]);
                end
            end
            OWN: begin
                if (bus.req[owner_q] && (cnt_q != '0)) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (win_found) begin
                    // Expiry or early release with someone pending. If the
                    // owner is the only one left it wins its own search and
                    // gets a fresh slice.
                    owner_d = win_idx;
                    ptr_d   = next_idx(win_idx);
                    cnt_d   = load_val(slice_q[win_idx]);
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode (Moore: depends on registered state only)
    always_comb begin
        bus.gnt        = '0;
        bus.gnt_id     = '0;
        bus.gnt_vld    = 1'b0;
        bus.slice_last = 1'b0;
        if (state_q == OWN) begin
            bus.gnt[owner_q] = 1'b1;
            bus.gnt_id       = owner_q;
            bus.gnt_vld      = 1'b1;
            bus.slice_last   = (cnt_q == '0);
        end
    end

endmodule

// File: tb/tb_slice_rr_scheduler.sv
module tb_slice_rr_scheduler;

    localparam int NREQ = 4;

    logic clk;
    logic rst;

    slice_rr_scheduler_if #(.NREQ(4), .SLICE_W(4)) bus ();

    slice_rr_scheduler #(.NREQ(4), .SLICE_W(4), .SLICE_RST(4'd3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic cmp(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: owner (-1 = nobody), cycles remaining in the slice
    // including the current one, and the round-robin resume point.
    int m_owner;
    int m_rem;
    int m_ptr;
    int m_start;
    int m_win;
    int m_eff;
    int m_slice [NREQ];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1;
            m_rem   = 0;
            m_ptr   = 0;
            for (int i = 0; i < NREQ; i++) m_slice[i] = 3;
        end else begin
            if (m_owner >= 0 && bus.req[m_owner[1:0]] && m_rem > 1) begin
                m_rem = m_rem - 1;
            end else begin
                m_start = (m_owner >= 0) ? (m_owner + 1) % NREQ : m_ptr;
                m_win   = -1;
                for (int i = 0; i < NREQ; i++) begin
                    if (m_win < 0 && bus.req[(m_start + i) % NREQ]) m_win = (m_start + i) % NREQ;
                end
                if (m_win >= 0) begin
                    m_eff   = (m_slice[m_win] == 0) ? 1 : m_slice[m_win];
                    m_owner = m_win;
                    m_rem   = m_eff;
                    m_ptr   = (m_win + 1) % NREQ;
                end else begin
                    m_owner = -1;
                    m_rem   = 0;
                end
            end
            if (bus.cfg_we) m_slice[int'(bus.cfg_idx)] = int'(bus.cfg_slice);
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        automatic int e_gnt  = (m_owner >= 0) ? (1 << m_owner) : 0;
        automatic int e_id   = (m_owner >= 0) ? m_owner : 0;
        automatic int e_vld  = (m_owner >= 0) ? 1 : 0;
        automatic int e_last = (m_owner >= 0 && m_rem == 1) ? 1 : 0;
        cmp("model_gnt", int'(bus.gnt), e_gnt);
        cmp("model_gnt_id", int'(bus.gnt_id), e_id);
        cmp("model_gnt_vld", int'(bus.gnt_vld), e_vld);
        cmp("model_slice_last", int'(bus.slice_last), e_last);
        cmp("onehot_gnt", ($countones(bus.gnt) <= 1) ? 1 : 0, 1);
    end

    // Cycle start = 1 time unit after the rising edge; all driving happens there.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the current cycle's outputs against literals, then advance.
    task automatic chk(input string nm, input logic [3:0] e_gnt, input logic e_last);
        @(negedge clk);
        cmp({nm, "_gnt"}, int'(bus.gnt), int'(e_gnt));
        cmp({nm, "_last"}, int'(bus.slice_last), int'(e_last));
        step();
    endtask

    task automatic do_reset();
        step();
        rst        = 1'b1;
        bus.req    = '0;
        bus.cfg_we = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic [3:0] val);
        bus.cfg_we    = 1'b1;
        bus.cfg_idx   = idx;
        bus.cfg_slice = val;
        step();
        bus.cfg_we = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.req       = '0;
        bus.cfg_we    = 1'b0;
        bus.cfg_idx   = '0;
        bus.cfg_slice = '0;
        step();
        @(negedge clk);
        cmp("reset_gnt", int'(bus.gnt), 0);
        cmp("reset_gnt_id", int'(bus.gnt_id), 0);
        cmp("reset_vld", int'(bus.gnt_vld), 0);
        cmp("reset_last", int'(bus.slice_last), 0);

        // Two requesters alternate in slices of 3
        do_reset();
        bus.req = 4'b0101;
        chk("rr_idle", 4'b0000, 1'b0);
        for (int i = 0; i < 9; i++) begin
            chk("rr_alt", ((i / 3) % 2 == 1) ? 4'b0100 : 4'b0001, (i % 3) == 2);
        end

        // Lone requester with a 5-cycle slice is re-granted seamlessly
        do_reset();
        cfg_write(2'd1, 4'd5);
        bus.req = 4'b0010;
        step();
        for (int i = 0; i < 10; i++) begin
            chk("slice5", 4'b0010, (i % 5) == 4);
        end

        // Early release in the 2nd cycle hands over on the next edge
        do_reset();
        bus.req = 4'b0001;
        step();
        chk("rel_c1", 4'b0001, 1'b0);
        bus.req = 4'b1000;
        chk("rel_c2", 4'b0001, 1'b0);
        chk("rel_new1", 4'b1000, 1'b0);
        chk("rel_new2", 4'b1000, 1'b0);
        chk("rel_new3", 4'b1000, 1'b1);

        // A slice of 0 behaves as 1
        do_reset();
        cfg_write(2'd2, 4'd0);
        bus.req = 4'b0100;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("slice0", 4'b0100, 1'b1);
        end

        // Asynchronous reset mid-slice
        do_reset();
        bus.req = 4'b0010;
        step();
        chk("arst_own", 4'b0010, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        cmp("arst_gnt", int'(bus.gnt), 0);
        cmp("arst_vld", int'(bus.gnt_vld), 0);
        step();
        rst = 1'b0;
        chk("arst_rel", 4'b0000, 1'b0);
        chk("arst_regrant", 4'b0010, 1'b0);

        // Write during the final cycle only affects the following load
        do_reset();
        bus.req = 4'b0001;
        step();
        chk("wr_c1", 4'b0001, 1'b0);
        chk("wr_c2", 4'b0001, 1'b0);
        bus.cfg_we    = 1'b1;
        bus.cfg_idx   = 2'd0;
        bus.cfg_slice = 4'd6;
        @(negedge clk);
        cmp("wr_c3_last", int'(bus.slice_last), 1);
        step();
        bus.cfg_we = 1'b0;
        for (int i = 0; i < 3; i++) chk("wr_old", 4'b0001, i == 2);
        for (int i = 0; i < 6; i++) chk("wr_new", 4'b0001, i == 5);

        // Randomized traffic, configuration and occasional resets
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom_range(0, 15));
            bus.cfg_we    = ($urandom_range(0, 9) == 0);
            bus.cfg_idx   = 2'($urandom_range(0, 3));
            bus.cfg_slice = 4'($urandom_range(0, 15));
            rst           = ($urandom_range(0, 199) == 0);
            step();
        end
        rst        = 1'b0;
        bus.cfg_we = 1'b0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/slice_rr_scheduler.md
SLICE_RR_SCHEDULER -- requirements
Module: slice_rr_scheduler

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters.
REQ-002 The block SHALL have parameter SLICE_W, default 4, giving the width of each slice-length register.
REQ-003 The block SHALL have parameter SLICE_RST, default 4'd3, giving the reset slice length for every requester.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port req, input, NREQ bits: per-requester request level, held while access is wanted.
REQ-007 Port cfg_we, input, 1 bit: slice-register write strobe.
REQ-008 Port cfg_idx, input, clog2(NREQ) bits: index of the slice register to write.
REQ-009 Port cfg_slice, input, SLICE_W bits: slice length in cycles to write.
REQ-010 Port gnt, output, NREQ bits: registered one-hot grant, or all-zero.
REQ-011 Port gnt_id, output, clog2(NREQ) bits: encoded index of the current owner.
REQ-012 Port gnt_vld, output, 1 bit: high exactly when gnt is non-zero.
REQ-013 Port slice_last, output, 1 bit: high in the final cycle of the current owner's slice.

Function
REQ-014 The FSM SHALL have two states: IDLE (no owner) and OWN (one owner k, down-counter cnt).
- Winner selection SHALL be a rotating-priority search starting at index k+1 (mod NREQ), with k itself checked last.
- In IDLE the search SHALL start at ptr.
REQ-015 IDLE, any req bit high in cycle t: gnt SHALL be the winner's one-hot from cycle t+1, with cnt=slice[winner]-1.
REQ-016 OWN, req[k]=1 and cnt>0: cnt SHALL decrement and the grant SHALL hold.
REQ-017 OWN, req[k]=1 and cnt=0 (expiry), another requester pending: the grant SHALL move to the winner on the next edge, with no idle gap.
REQ-018 OWN, req[k]=1 and cnt=0, no other requester pending: k SHALL be re-granted and cnt reloaded.
REQ-019 OWN, req[k]=0 (early release): the grant SHALL move to the winner on the next edge, or to IDLE with gnt=0 if no req bit is high.
REQ-020 On every grant change, ptr SHALL be set to owner+1 (mod NREQ).
REQ-021 A slice register value of 0 SHALL be treated as 1.
- cnt SHALL be SLICE_W bits and SHALL never wrap below 0.
REQ-022 A cfg_we write SHALL update slice[cfg_idx] at the edge.
- The new value SHALL take effect only at the next load for that requester; a load in the same cycle SHALL use the old value.
REQ-023 slice_last SHALL be high iff state is OWN and cnt=0.
REQ-024 gnt SHALL never have more than one bit set, and SHALL never be non-zero in IDLE.

Reset
REQ-025 While rst=1, the block SHALL hold: state=IDLE, gnt=0, gnt_id=0, gnt_vld=0, slice_last=0, cnt=0, ptr=0, every slice register=SLICE_RST.
REQ-026 Reset asserted mid-slice SHALL clear gnt asynchronously, with no completion of the slice.
REQ-027 After reset release, the first grant SHALL follow REQ-015.

Structure
REQ-028 Package slice_rr_pkg SHALL hold the state enum (IDLE, OWN), NREQ, SLICE_W and SLICE_RST.
REQ-029 Sub-module rr_pick (combinational rotating-priority encoder: req, start index -> winner index and found flag) SHALL be instantiated once.

Verification
REQ-030 Reset, then req=4'b0101 held: gnt SHALL be 0001 for 3 cycles, then 0100 for 3 cycles, then 0001, repeating.
REQ-031 Write slice[1]=5, then req=4'b0010 held: gnt SHALL be 0010 continuously, with slice_last pulsing every 5th cycle.
REQ-032 Owner 0 with slice=3, req[0] dropped in the 2nd cycle while req=4'b1000: gnt SHALL be 1000 on the next edge.
REQ-033 Write slice[2]=0, req=4'b0100: gnt SHALL be 0100 with slice_last high every cycle.
REQ-034 rst pulsed while gnt=0010: gnt SHALL be 0000 immediately; after release with req=4'b0010, gnt SHALL be 0010 one cycle later.
REQ-035 Write slice[0]=6 during owner 0's final cycle: the re-grant SHALL last 3 cycles and the following grant of 0 SHALL last 6 cycles.
